// File: rtl/sseg_pkg.sv
// Shared types and sizes for the seven-segment display scheduler.
package sseg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int NIBBLE_W   = 4;
  localparam int IDX_W      = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {
    OWN_A = 2'd0,
    OWN_B = 2'd1,
    GUARD = 2'd2
  } sched_state_e;

  function automatic logic [NUM_DIGITS-1:0] anode_onehot_n(input logic [IDX_W-1:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction
endpackage

// File: rtl/sseg_sched_if.sv
// Requester and display-side signals of the scheduler; slave = scheduler, master = its environment.
interface sseg_sched_if;
  import sseg_pkg::*;

  logic [NUM_DIGITS*NIBBLE_W-1:0] a_digits;
  logic                           b_req;
  logic [NUM_DIGITS*NIBBLE_W-1:0] b_digits;
  logic                           b_grant;
  logic                           b_done;
  logic                           owner;
  logic [NUM_DIGITS-1:0]          an_sel;
  logic [NIBBLE_W-1:0]            char_sel;

  modport master (
    output a_digits, b_req, b_digits,
    input  b_grant, b_done, owner, an_sel, char_sel
  );

  modport slave (
    input  a_digits, b_req, b_digits,
    output b_grant, b_done, owner, an_sel, char_sel
  );
endinterface

// File: rtl/sseg_scan_timer.sv
// Digit-slot prescaler and digit index; flags the tick that starts a new frame.
module sseg_scan_timer
  import sseg_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  output logic             tick_o,
  output logic [IDX_W-1:0] idx_nxt_o,
  output logic             frame_o
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  assign tick_o    = (presc_q == PW'(SCAN_DIV - 1));
  assign idx_nxt_o = idx_q + 1'b1;
  assign frame_o   = tick_o && (idx_q == IDX_W'(NUM_DIGITS - 1));

  always_comb begin
    presc_d = tick_o ? '0 : presc_q + 1'b1;
    idx_d   = tick_o ? idx_nxt_o : idx_q;
  end

  // Index resets to the last digit so the first tick opens a frame at digit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= IDX_W'(NUM_DIGITS - 1);
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end
endmodule

// File: rtl/sseg_sched.sv
// Display ownership scheduler: A owns by default, B borrows whole frames with a hold limit and a guard.
//   state | meaning
//   OWN_A | A's value shown; a B request is honoured at the next frame boundary
//   OWN_B | B's value shown; hold counter counts remaining frames
//   GUARD | A's value shown; B requests ignored until the guard counter expires
module sseg_sched
  import sseg_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int HOLD_FRAMES  = 250,
  parameter int GUARD_FRAMES = 125
) (
  input logic         clk,
  input logic         rst,
  sseg_sched_if.slave bus
);
  localparam int CNT_MAX = (HOLD_FRAMES > GUARD_FRAMES) ? HOLD_FRAMES : GUARD_FRAMES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int FRAME_W = NUM_DIGITS * NIBBLE_W;

  logic             tick;
  logic             frame;
  logic [IDX_W-1:0] idx_nxt;

  sseg_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .tick_o    (tick),
    .idx_nxt_o (idx_nxt),
    .frame_o   (frame)
  );

  sched_state_e          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_W-1:0]    fbuf_q, fbuf_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [NIBBLE_W-1:0]   char_q, char_d;
  logic                  done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fbuf_d  = fbuf_q;
    an_d    = an_q;
    char_d  = char_q;
    done_d  = 1'b0;

    if (frame) begin
      unique case (state_q)
        OWN_A: begin
          if (bus.b_req) begin
            state_d = OWN_B;
            cnt_d   = CNT_W'(HOLD_FRAMES - 1);
          end
        end
        OWN_B: begin
          // A request drop and hold expiry at the same boundary take one exit path.
          if (!bus.b_req || cnt_q == '0) begin
            state_d = GUARD;
            cnt_d   = CNT_W'(GUARD_FRAMES - 1);
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        GUARD: begin
          if (cnt_q == '0) state_d = OWN_A;
          else             cnt_d   = cnt_q - 1'b1;
        end
        default: state_d = OWN_A;
      endcase
      fbuf_d = (state_d == OWN_B) ? bus.b_digits : bus.a_digits;
    end

    // fbuf_d already holds the new frame at a boundary, so digit 0 is never torn.
    if (tick) begin
      an_d   = anode_onehot_n(idx_nxt);
      char_d = fbuf_d[idx_nxt*NIBBLE_W +: NIBBLE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OWN_A;
      cnt_q   <= '0;
      fbuf_q  <= '0;
      an_q    <= '1;
      char_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fbuf_q  <= fbuf_d;
      an_q    <= an_d;
      char_q  <= char_d;
      done_q  <= done_d;
    end
  end

  assign bus.b_grant  = (state_q == OWN_B);
  assign bus.owner    = (state_q == OWN_B);
  assign bus.b_done   = done_q;
  assign bus.an_sel   = an_q;
  assign bus.char_sel = char_q;
endmodule

// File: tb/tb_sseg_sched.sv
// Bench for sseg_sched: two instances (HOLD/GUARD = 3/2 and 1/1) against a frame-level ownership model.
module tb_sseg_sched;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sseg_sched_if bus0();
  sseg_sched_if bus1();

  assign bus1.a_digits = bus0.a_digits;
  assign bus1.b_req    = bus0.b_req;
  assign bus1.b_digits = bus0.b_digits;

  sseg_sched #(.SCAN_DIV(SD), .HOLD_FRAMES(3), .GUARD_FRAMES(2)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  sseg_sched #(.SCAN_DIV(SD), .HOLD_FRAMES(1), .GUARD_FRAMES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  int checks   = 0;
  int failures = 0;
  int k        = 0;
  int done_cnt0, done_cnt1, last_done0;

  // Model: global cycle count gives the scan position; owner decided per frame from frame counts.
  int          m_n;
  logic [3:0]  m_an;
  logic [15:0] m_fv   [2];
  int          m_mode [2];  // 0 = A, 1 = B, 2 = guard
  int          m_used [2];  // frames spent in the current B or guard run, counting the current one
  logic [3:0]  m_char [2];
  logic        m_done [2];

  function automatic int hold_of(input int i);
    return (i == 0) ? 3 : 1;
  endfunction

  function automatic int guard_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic model_reset();
    m_n  = 0;
    m_an = 4'hF;
    for (int i = 0; i < 2; i++) begin
      m_fv[i] = '0; m_mode[i] = 0; m_used[i] = 0; m_char[i] = '0; m_done[i] = 1'b0;
    end
  endtask

  task automatic model_step(input logic req, input logic [15:0] a, input logic [15:0] b);
    int t, dig;
    for (int i = 0; i < 2; i++) m_done[i] = 1'b0;
    if (m_n % SD == SD - 1) begin
      t   = (m_n + 1) / SD;
      dig = (t - 1) % 4;
      if (dig == 0) begin
        for (int i = 0; i < 2; i++) begin
          case (m_mode[i])
            0: if (req) begin m_mode[i] = 1; m_used[i] = 1; end
            1: begin
              if (!req || m_used[i] == hold_of(i)) begin
                m_mode[i] = 2; m_used[i] = 1; m_done[i] = 1'b1;
              end else m_used[i]++;
            end
            default: begin
              if (m_used[i] == guard_of(i)) m_mode[i] = 0;
              else m_used[i]++;
            end
          endcase
          m_fv[i] = (m_mode[i] == 1) ? b : a;
        end
      end
      m_an = ~(4'b0001 << dig);
      for (int i = 0; i < 2; i++) m_char[i] = m_fv[i][dig*4 +: 4];
    end
    m_n++;
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d actual=%h required=%h", nm, k, act, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic req, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    rst           = r;
    bus0.b_req    = req;
    bus0.a_digits = a;
    bus0.b_digits = b;
    if (r) model_reset();
    else   model_step(req, a, b);
    @(posedge clk);
    #1;
    if (r) k = 0;
    else   k++;
    check("an0",    16'(bus0.an_sel),   16'(m_an));
    check("char0",  16'(bus0.char_sel), 16'(m_char[0]));
    check("owner0", 16'(bus0.owner),    16'(m_mode[0] == 1));
    check("grant0", 16'(bus0.b_grant),  16'(m_mode[0] == 1));
    check("done0",  16'(bus0.b_done),   16'(m_done[0]));
    check("an1",    16'(bus1.an_sel),   16'(m_an));
    check("char1",  16'(bus1.char_sel), 16'(m_char[1]));
    check("owner1", 16'(bus1.owner),    16'(m_mode[1] == 1));
    check("grant1", 16'(bus1.b_grant),  16'(m_mode[1] == 1));
    check("done1",  16'(bus1.b_done),   16'(m_done[1]));
    if (!r) begin
      done_cnt0 += int'(bus0.b_done);
      done_cnt1 += int'(bus1.b_done);
      if (bus0.b_done) last_done0 = k;
    end
  endtask

  task automatic do_reset(input logic req, input logic [15:0] a, input logic [15:0] b);
    cycle(1'b1, req, a, b);
    cycle(1'b1, req, a, b);
    done_cnt0 = 0; done_cnt1 = 0; last_done0 = -1;
  endtask

  typedef struct {
    int         k;
    logic [3:0] an;
    logic [3:0] ch;
  } vec_t;

  vec_t        tbl [12];
  logic [6:0]  own_exp0, own_exp1;
  logic        req;
  logic [15:0] a_val;
  int          j, f;

  initial begin
    bus0.b_req = 1'b0; bus0.a_digits = '0; bus0.b_digits = '0;

    tbl[0]  = '{1,  4'hF, 4'h0};
    tbl[1]  = '{3,  4'hF, 4'h0};
    tbl[2]  = '{4,  4'hE, 4'h4};
    tbl[3]  = '{7,  4'hE, 4'h4};
    tbl[4]  = '{8,  4'hD, 4'h3};
    tbl[5]  = '{12, 4'hB, 4'h2};
    tbl[6]  = '{16, 4'h7, 4'h1};
    tbl[7]  = '{19, 4'h7, 4'h1};
    tbl[8]  = '{20, 4'hE, 4'h4};
    tbl[9]  = '{24, 4'hD, 4'h3};
    tbl[10] = '{28, 4'hB, 4'h2};
    tbl[11] = '{32, 4'h7, 4'h1};

    // Scan order and reset display state with A only.
    do_reset(1'b0, 16'h1234, 16'h0);
    check("rst_an",    16'(bus0.an_sel),   16'hF);
    check("rst_char",  16'(bus0.char_sel), 16'h0);
    check("rst_owner", 16'(bus0.owner),    16'h0);
    j = 0;
    for (int c = 1; c <= 32; c++) begin
      cycle(1'b0, 1'b0, 16'h1234, 16'h0);
      if (j < 12 && tbl[j].k == k) begin
        check("tbl_an",   16'(bus0.an_sel),   16'(tbl[j].an));
        check("tbl_char", 16'(bus0.char_sel), 16'(tbl[j].ch));
        j++;
      end
    end
    check("tbl_cover", 16'(j), 16'd12);

    // Continuous B request: grant, hold limit, guard, regrant.
    own_exp0 = 7'b1000111;
    own_exp1 = 7'b1001001;
    do_reset(1'b1, 16'h1234, 16'hABCD);
    for (int c = 1; c <= 112; c++) begin
      cycle(1'b0, 1'b1, 16'h1234, 16'hABCD);
      if ((k - 4) % 16 == 0) begin
        f = (k - 4) / 16;
        check("hold_owner0", 16'(bus0.owner), 16'(own_exp0[f]));
        check("hold_owner1", 16'(bus1.owner), 16'(own_exp1[f]));
      end
    end
    check("hold_done_cnt0", 16'(done_cnt0),  16'd1);
    check("hold_done_k0",   16'(last_done0), 16'd52);
    check("hold_done_cnt1", 16'(done_cnt1),  16'd2);

    // Mid-frame glitch is ignored; a drop spanning a boundary releases there.
    do_reset(1'b1, 16'h1234, 16'hABCD);
    for (int c = 1; c <= 48; c++) begin
      req = !((c >= 22 && c <= 24) || (c >= 33 && c <= 40));
      cycle(1'b0, req, 16'h1234, 16'hABCD);
      if (k == 35) check("glitch_owner0", 16'(bus0.owner), 16'h1);
      if (k == 36) check("drop_owner0",   16'(bus0.owner), 16'h0);
    end
    check("drop_done_cnt0", 16'(done_cnt0),  16'd1);
    check("drop_done_k0",   16'(last_done0), 16'd36);

    // Drop coinciding with hold expiry, then guard ignores the request.
    do_reset(1'b1, 16'h1234, 16'hABCD);
    for (int c = 1; c <= 104; c++) begin
      req = !(c >= 50 && c <= 53);
      cycle(1'b0, req, 16'h1234, 16'hABCD);
      if (k == 68)  check("coin_guard_owner0", 16'(bus0.owner), 16'h0);
      if (k == 84)  check("coin_a_owner0",     16'(bus0.owner), 16'h0);
      if (k == 100) check("coin_regrant0",     16'(bus0.owner), 16'h1);
    end
    check("coin_done_cnt0", 16'(done_cnt0),  16'd1);
    check("coin_done_k0",   16'(last_done0), 16'd52);

    // Reset in the middle of a grant.
    do_reset(1'b1, 16'h1234, 16'hABCD);
    for (int c = 1; c <= 26; c++) cycle(1'b0, 1'b1, 16'h1234, 16'hABCD);
    check("pre_rst_grant0", 16'(bus0.b_grant), 16'h1);
    cycle(1'b1, 1'b1, 16'h1234, 16'hABCD);
    check("mid_rst_grant0", 16'(bus0.b_grant), 16'h0);
    check("mid_rst_owner0", 16'(bus0.owner),   16'h0);
    check("mid_rst_an0",    16'(bus0.an_sel),  16'hF);
    check("mid_rst_done0",  16'(bus0.b_done),  16'h0);

    // Random traffic; b_digits changes every cycle.
    do_reset(1'b0, 16'h0, 16'h0);
    req   = 1'b0;
    a_val = 16'(($urandom));
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(23, 0) == 0) req = ~req;
      if ($urandom_range(39, 0) == 0) a_val = 16'($urandom);
      cycle(($urandom_range(1499, 0) == 0), req, a_val, 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
